biu_regfile_slave: RTL

//  Register-file responder on the BIU slave-side interface (the biu_slave o_* / i_* pins).

---
 rtl/biu_regfile_slave.sv | 108 ++++++++++
 1 files changed

// File: rtl/biu_regfile_slave.sv
// biu_regfile_slave: register bank behind biu_slave.
// Scratch, status and free-running count with fixed-latency read return.
module biu_regfile_slave #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'hc0000010,
  parameter int                    NUM_REGS     = 4,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_rnw,
  input  logic                  i_en,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_reg0
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] IDX_ST  = IW'(NUM_REGS - 2);
  localparam logic [IW-1:0] IDX_CNT = IW'(NUM_REGS - 1);

  logic [ADDR_WIDTH-1:0] off;
  logic [IW-1:0]         idx;
  logic                  hit;
  logic                  wr;
  logic                  rd;
  logic                  is_st;
  logic                  is_cnt;
  logic                  is_scr;

  logic [DATA_WIDTH-1:0] scr [NUM_REGS];
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  err;
  logic [7:0]            wcnt;

  logic [DATA_WIDTH-1:0]   pdata [READ_LATENCY];
  logic [READ_LATENCY-1:0] pvld;

  assign off    = i_address - BASE_ADDR;
  assign idx    = off[IW+1:2];
  assign hit    = (off[1:0] == 2'b00) &&
                  (off[ADDR_WIDTH-1:IW+2] == '0);
  assign wr     = i_en && !i_rnw;
  assign rd     = i_en && i_rnw;
  assign is_st  = (idx == IDX_ST);
  assign is_cnt = (idx == IDX_CNT);
  assign is_scr = (idx < IDX_ST);

  always_comb begin
    status       = '0;
    status[15:8] = wcnt;
    status[0]    = err;
  end

  always_comb begin
    rd_data = DATA_WIDTH'(32'hDEADBEEF);
    if (hit) begin
      unique case (1'b1)
        is_cnt:  rd_data = count;
        is_st:   rd_data = status;
        default: rd_data = scr[idx];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        scr[i] <= '0;
      count <= '0;
      err   <= 1'b0;
      wcnt  <= '0;
      pvld  <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pdata[i] <= '0;
    end else begin
      if (wr && hit && is_cnt)
        count <= i_data_in;
      else
        count <= count + DATA_WIDTH'(1);
      if (wr && hit && is_scr)
        scr[idx] <= i_data_in;
      if (wr && hit)
        wcnt <= wcnt + 8'd1;
      // a miss in the same cycle outranks the W1C clear
      if (i_en && !hit)
        err <= 1'b1;
      else if (wr && hit && is_st && i_data_in[0])
        err <= 1'b0;
      pvld[0]  <= rd;
      pdata[0] <= rd ? rd_data : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pvld[i]  <= pvld[i-1];
        pdata[i] <= pdata[i-1];
      end
    end
  end

  assign o_data_out   = pdata[READ_LATENCY-1];
  assign o_data_valid = pvld[READ_LATENCY-1];
  assign o_reg0       = scr[0];

endmodule
